// File: rtl/ball_trajectory.sv
// ----------------------------------------------------------------------------
// ball_trajectory
// Integrates the ball's flight from latched launch velocities. Position and
// vertical velocity live in signed fixed-point accumulators (FRAC fractional
// bits). Each tick advances the position and applies gravity. The flight ends
// on ground contact or when the ball passes the right edge of the field.
//
// Ports
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_launch         single-cycle launch request (honoured in IDLE and DONE)
//   i_tick           single-cycle time-step enable (honoured in FLY)
//   i_vel_x[9:0]     unsigned horizontal launch velocity, fractional units/tick
//   i_vel_y[9:0]     unsigned vertical launch velocity, fractional units/tick
//   o_pos_x[9:0]     ball column in pixels
//   o_pos_y[9:0]     ball height in pixels above ground
//   o_in_flight      high while flying
//   o_landed         one-cycle pulse on the tick that ends the flight
//   o_out_of_bounds  sticky flag: the flight ended at the right edge
//   o_step_cnt[9:0]  ticks in the current flight, saturating at 1023
// ----------------------------------------------------------------------------
module ball_trajectory #(
    parameter int FRAC  = 7,
    parameter int GRAV  = 8,
    parameter int X_MAX = 639,
    parameter int ACC_W = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_launch,
    input  logic       i_tick,
    input  logic [9:0] i_vel_x,
    input  logic [9:0] i_vel_y,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_in_flight,
    output logic       o_landed,
    output logic       o_out_of_bounds,
    output logic [9:0] o_step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] GRAV_A = ACC_W'(GRAV);
    // First horizontal accumulator value whose pixel column exceeds X_MAX.
    localparam logic [ACC_W-1:0] PX_LIM = ACC_W'((X_MAX + 1) * (2 ** FRAC));
    // Horizontal accumulator value parked at when the ball leaves the field.
    localparam logic [ACC_W-1:0] PX_EDGE = ACC_W'(X_MAX * (2 ** FRAC));

    state_t                   r_state;
    state_t                   w_state_n;
    logic [ACC_W-1:0]         r_px,  w_px_n;
    logic signed [ACC_W-1:0]  r_py,  w_py_n;
    logic [ACC_W-1:0]         r_vx,  w_vx_n;
    logic signed [ACC_W-1:0]  r_vy,  w_vy_n;
    logic [9:0]               r_step, w_step_n;
    logic                     r_oob, w_oob_n;
    logic                     r_landed, w_landed_n;
    logic                     r_in_flight, w_in_flight_n;

    // Candidate values for a flight step, used only when a tick lands in FLY.
    logic [ACC_W-1:0]         w_px_adv;
    logic signed [ACC_W-1:0]  w_py_adv;
    logic                     w_ground;
    logic                     w_edge;

    assign w_px_adv = r_px + r_vx;
    assign w_py_adv = r_py + r_vy;
    assign w_ground = w_py_adv[ACC_W-1] || (w_py_adv == {ACC_W{1'b0}});
    // px is never negative, so an unsigned compare against the limit suffices.
    assign w_edge   = (w_px_adv >= PX_LIM);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_n  = r_state;
        w_px_n     = r_px;
        w_py_n     = r_py;
        w_vx_n     = r_vx;
        w_vy_n     = r_vy;
        w_step_n   = r_step;
        w_oob_n    = r_oob;
        w_landed_n = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_launch) begin
                    w_state_n = ST_FLY;
                    w_px_n    = {ACC_W{1'b0}};
                    w_py_n    = {ACC_W{1'b0}};
                    w_vx_n    = {{(ACC_W-10){1'b0}}, i_vel_x};
                    w_vy_n    = {{(ACC_W-10){1'b0}}, i_vel_y};
                    w_step_n  = 10'd0;
                    w_oob_n   = 1'b0;
                end else begin
                    w_state_n = r_state;
                end
            end
            ST_FLY: begin
                if (i_tick) begin
                    w_px_n   = w_px_adv;
                    w_py_n   = w_py_adv;
                    w_vy_n   = r_vy - GRAV_A;
                    w_step_n = (r_step == 10'h3FF) ? r_step : (r_step + 10'd1);
                    if (w_ground || w_edge) begin
                        w_state_n  = ST_DONE;
                        w_landed_n = 1'b1;
                    end else begin
                        w_state_n  = ST_FLY;
                    end
                    if (w_ground) begin
                        w_py_n = {ACC_W{1'b0}};
                    end else begin
                        w_py_n = w_py_adv;
                    end
                    if (w_edge) begin
                        w_px_n  = PX_EDGE;
                        w_oob_n = 1'b1;
                    end else begin
                        w_px_n  = w_px_adv;
                    end
                end else begin
                    w_state_n = ST_FLY;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
        w_in_flight_n = (w_state_n == ST_FLY);
    end

    // Datapath and flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_px        <= {ACC_W{1'b0}};
            r_py        <= {ACC_W{1'b0}};
            r_vx        <= {ACC_W{1'b0}};
            r_vy        <= {ACC_W{1'b0}};
            r_step      <= 10'd0;
            r_oob       <= 1'b0;
            r_landed    <= 1'b0;
            r_in_flight <= 1'b0;
        end else begin
            r_px        <= w_px_n;
            r_py        <= w_py_n;
            r_vx        <= w_vx_n;
            r_vy        <= w_vy_n;
            r_step      <= w_step_n;
            r_oob       <= w_oob_n;
            r_landed    <= w_landed_n;
            r_in_flight <= w_in_flight_n;
        end
    end

    // Pixel coordinates are plain bit slices of the position registers.
    assign o_pos_x         = r_px[FRAC+9:FRAC];
    assign o_pos_y         = r_py[FRAC+9:FRAC];
    assign o_in_flight     = r_in_flight;
    assign o_landed        = r_landed;
    assign o_out_of_bounds = r_oob;
    assign o_step_cnt      = r_step;

endmodule

// File: doc/ball_trajectory.md
Name: ball_trajectory

Overview:
Integrates the ball's flight from the launch velocity components produced by the velocity/angle lookup stage. On a launch pulse it latches vel_x/vel_y. On each time-step tick it advances fixed-point position and applies constant gravity to the vertical velocity. It stops at ground contact or at the right edge of the play field. It feeds the pixel renderer with integer pixel coordinates and flight status.

Parameters:
FRAC, 7, fractional bits of position/velocity accumulators (1 px = 2^FRAC units)
GRAV, 8, gravity: subtracted from vertical velocity each tick, in fractional units
X_MAX, 639, rightmost legal pixel column
ACC_W, 20, signed accumulator width for position and vertical velocity

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
launch  in  1  single-cycle launch request
tick  in  1  single-cycle time-step enable
vel_x  in  10  unsigned horizontal launch velocity, fractional units/tick
vel_y  in  10  unsigned vertical launch velocity, fractional units/tick
pos_x  out  10  ball column in pixels (px_acc >> FRAC)
pos_y  out  10  ball height in pixels above ground (py_acc >> FRAC)
in_flight  out  1  high while in FLY
landed  out  1  one-cycle pulse on the tick that ends the flight
out_of_bounds  out  1  sticky; flight ended at X_MAX
step_cnt  out  10  ticks elapsed in current flight, saturates at 1023

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high. While rst is asserted: state=IDLE, all accumulators 0, all outputs 0.
- All outputs are registered and change only on the clk rising edge.
- States: IDLE, FLY, DONE.
- IDLE --launch--> FLY.
  - Latch vx=vel_x and vy=vel_y (zero-extended to ACC_W, vy signed). Clear px, py, step_cnt and out_of_bounds.
  - in_flight=1 from the next cycle.
  - tick in the same cycle as launch is ignored; the first update happens on the next tick.
- FLY, on tick:
  - px_n = px + vx; py_n = py + vy; vy_n = vy - GRAV (signed; vy may go negative).
  - step_cnt += 1, saturating at 1023.
  - Ground: py_n <= 0 (signed) -> py=0, px=px_n, go to DONE, landed=1 for one cycle, in_flight=0.
  - Edge: (px_n >> FRAC) > X_MAX -> pos_x=X_MAX, px holds X_MAX<<FRAC, go to DONE, landed=1, out_of_bounds=1.
  - Ground and edge on the same tick: both apply. Result is pos_x=X_MAX, pos_y=0, out_of_bounds=1, single landed pulse.
  - Otherwise the new values are committed and the state remains FLY.
- FLY without tick: all state held.
- launch in FLY is ignored.
- DONE:
  - Positions, step_cnt and out_of_bounds are held and tick is ignored.
  - launch -> relatch and enter FLY exactly as from IDLE.
- pos_x/pos_y = accumulator >> FRAC, truncated to 10 bits.
  - py is never negative in a committed state.
  - px never exceeds X_MAX<<FRAC.
- Latency: a tick on cycle n is reflected on the outputs at cycle n+1.
- Reset asserted mid-flight: immediate return to IDLE and zero outputs, no landed pulse. After release, the block waits for a new launch.

Test Plan:
- Reset values: hold rst, drive launch/tick randomly -> all outputs 0. Release rst, no launch -> outputs remain 0, state IDLE.
- Short arc: launch with vel_x=120, vel_y=10, GRAV=8, then 4 ticks.
  - py sequence is 10, 12, 6, then landing on tick 4 (py_n=-8).
  - Required: landed pulse on tick 4, pos_x=3 (480>>7), pos_y=0, step_cnt=4, out_of_bounds=0, in_flight 1->0.
- Zero vertical velocity: vel_x=52, vel_y=0 -> lands on the first tick. Required: pos_x=0, pos_y=0, step_cnt=1, landed pulse.
- Edge hit: vel_x=717, vel_y=717, GRAV=8, tick until exit.
  - Required: flight ends on the first tick with (px_n>>7) > 639.
  - At that point pos_x=639, out_of_bounds=1, landed one pulse, tick count matches the golden model.
- Handshake corners:
  - launch+tick in the same cycle -> no position change that cycle.
  - launch during FLY -> ignored, trajectory unchanged.
  - launch in DONE -> new flight from 0, out_of_bounds cleared.
- Async reset mid-flight: assert rst between clock edges after 10 ticks -> outputs go to 0 immediately, no landed pulse, IDLE after release.
